rule_conf_loader: RTL and testbench

- Initiator side of the parser rule-configuration write interface.
- Accepts one packed rule descriptor per valid/ready handshake from the host/control path.
- Serializes the descriptor into a sequence of single-word configuration writes (addr/wdata/wren) that the rule-configuration register block consumes.
- Write order guarantees that a rule's valid bit is committed only after all of its type and key fields are written.

---
 rtl/rule_conf_loader.sv | 197 +++++++++++++++++++
 tb/tb_rule_conf_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_conf_loader.sv
// Rule-configuration write initiator: turns one packed rule descriptor into an
// ordered burst of single-word register writes, committing the valid bit last.
module rule_conf_loader #(
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int TYPE_WIDTH        = 16,
    parameter int KEY_FILED_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 8,
    parameter int RULE_NUM          = 8
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_desc_valid,
    output logic                                      o_desc_ready,
    input  logic [5:0]                                i_desc_rule_id,
    input  logic                                      i_desc_rule_valid,
    input  logic                                      i_desc_upd_offset,
    input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     i_desc_type_offset,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_desc_type_data,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_desc_type_mask,
    input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] i_desc_key_offset,
    output logic                                      o_rule_wren,
    input  logic                                      i_rule_wr_ready,
    output logic [31:0]                               o_rule_addr,
    output logic [31:0]                               o_rule_wdata,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic                                      o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFFSET,
        S_TYPE,
        S_KEY,
        S_COMMIT
    } state_t;

    localparam logic [5:0] TYPE_LAST = 6'(TYPE_NUM - 1);
    localparam logic [5:0] KEY_LAST  = 6'(KEY_FILED_NUM - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] cnt;
    logic [5:0] next_cnt;

    logic [5:0]                                rule_id_q;
    logic                                      rule_valid_q;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     type_offset_q;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]            type_data_q;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]            type_mask_q;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] key_offset_q;

    logic accept;
    logic reject;
    logic wr_fire;

    assign o_desc_ready = (state == S_IDLE) && !i_rst;
    assign accept       = i_desc_valid && o_desc_ready;
    assign reject       = {1'b0, i_desc_rule_id} >= 7'(RULE_NUM);
    assign wr_fire      = o_rule_wren && i_rule_wr_ready;
    assign o_busy       = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_done <= (state == S_COMMIT) && wr_fire;
            o_err  <= accept && reject;
        end
    end

    // NOTE: descriptor registers are pure datapath, only ever read while the
    // FSM is outside IDLE, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            rule_id_q     <= i_desc_rule_id;
            rule_valid_q  <= i_desc_rule_valid;
            type_offset_q <= i_desc_type_offset;
            type_data_q   <= i_desc_type_data;
            type_mask_q   <= i_desc_type_mask;
            key_offset_q  <= i_desc_key_offset;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            S_IDLE: begin
                next_cnt = '0;
                if (accept && !reject) begin
                    if (!i_desc_rule_valid)     next_state = S_COMMIT;
                    else if (i_desc_upd_offset) next_state = S_OFFSET;
                    else                        next_state = S_TYPE;
                end
            end
            S_OFFSET: begin
                if (wr_fire) begin
                    if (cnt == TYPE_LAST) begin
                        next_state = S_TYPE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 6'd1;
                    end
                end
            end
            S_TYPE: begin
                if (wr_fire) begin
                    if (cnt == TYPE_LAST) begin
                        next_state = S_KEY;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 6'd1;
                    end
                end
            end
            S_KEY: begin
                if (wr_fire) begin
                    if (cnt == KEY_LAST) begin
                        next_state = S_COMMIT;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 6'd1;
                    end
                end
            end
            S_COMMIT: begin
                if (wr_fire) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Write word is a pure function of state, count and the captured
    // descriptor, so it holds stable by construction while the sink stalls.
    always_comb begin
        o_rule_wren  = 1'b0;
        o_rule_addr  = '0;
        o_rule_wdata = '0;
        unique case (state)
            S_OFFSET: begin
                o_rule_wren      = 1'b1;
                o_rule_addr[3:0] = cnt[3:0];
                o_rule_wdata[TYPE_OFFSET_WIDTH-1:0] =
                    type_offset_q[int'(cnt)*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH];
            end
            S_TYPE: begin
                o_rule_wren      = 1'b1;
                o_rule_addr[16]  = 1'b1;
                o_rule_addr[9:8] = 2'b01;
                o_rule_addr[3:0] = cnt[3:0];
                o_rule_wdata[16 +: TYPE_WIDTH] =
                    type_data_q[int'(cnt)*TYPE_WIDTH +: TYPE_WIDTH];
                o_rule_wdata[0 +: TYPE_WIDTH] =
                    type_mask_q[int'(cnt)*TYPE_WIDTH +: TYPE_WIDTH];
            end
            S_KEY: begin
                o_rule_wren      = 1'b1;
                o_rule_addr[16]  = 1'b1;
                o_rule_addr[9:8] = 2'b10;
                o_rule_addr[5:0] = cnt;
                o_rule_wdata[0 +: KEY_OFFSET_WIDTH] =
                    key_offset_q[int'(cnt)*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH];
            end
            S_COMMIT: begin
                o_rule_wren      = 1'b1;
                o_rule_addr[16]  = 1'b1;
                o_rule_addr[5:0] = rule_id_q;
                o_rule_wdata[0]  = rule_valid_q;
            end
            default: begin
                o_rule_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rule_conf_loader.sv
// Scoreboard bench for rule_conf_loader: a descriptor-level model queues the
// expected write words; a negedge monitor checks every presented write and status.
module tb_rule_conf_loader;

    localparam int TYPE_NUM          = 4;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int TYPE_WIDTH        = 16;
    localparam int KEY_FILED_NUM     = 8;
    localparam int KEY_OFFSET_WIDTH  = 8;
    localparam int RULE_NUM          = 8;

    logic                                      i_clk;
    logic                                      i_rst;
    logic                                      i_desc_valid;
    logic                                      o_desc_ready;
    logic [5:0]                                i_desc_rule_id;
    logic                                      i_desc_rule_valid;
    logic                                      i_desc_upd_offset;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     i_desc_type_offset;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_desc_type_data;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_desc_type_mask;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] i_desc_key_offset;
    logic                                      o_rule_wren;
    logic                                      i_rule_wr_ready;
    logic [31:0]                               o_rule_addr;
    logic [31:0]                               o_rule_wdata;
    logic                                      o_busy;
    logic                                      o_done;
    logic                                      o_err;

    rule_conf_loader #(
        .TYPE_NUM          (TYPE_NUM),
        .TYPE_OFFSET_WIDTH (TYPE_OFFSET_WIDTH),
        .TYPE_WIDTH        (TYPE_WIDTH),
        .KEY_FILED_NUM     (KEY_FILED_NUM),
        .KEY_OFFSET_WIDTH  (KEY_OFFSET_WIDTH),
        .RULE_NUM          (RULE_NUM)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_desc_valid       (i_desc_valid),
        .o_desc_ready       (o_desc_ready),
        .i_desc_rule_id     (i_desc_rule_id),
        .i_desc_rule_valid  (i_desc_rule_valid),
        .i_desc_upd_offset  (i_desc_upd_offset),
        .i_desc_type_offset (i_desc_type_offset),
        .i_desc_type_data   (i_desc_type_data),
        .i_desc_type_mask   (i_desc_type_mask),
        .i_desc_key_offset  (i_desc_key_offset),
        .o_rule_wren        (o_rule_wren),
        .i_rule_wr_ready    (i_rule_wr_ready),
        .o_rule_addr        (o_rule_addr),
        .o_rule_wdata       (o_rule_wdata),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          last;
    } wr_t;

    wr_t exp_q[$];
    int  checks    = 0;
    int  failures  = 0;
    int  cycle     = 0;
    int  done_due  = -1;
    int  err_due   = -1;
    int  pops      = 0;
    int  rdy_mode  = 0;
    int  pat_base  = 0;
    int  pat_idx   = 0;
    bit  pat[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cycle <= cycle + 1;

    // Reference model: the write list a descriptor must produce, in order.
    task automatic model_push();
        wr_t w;
        if (int'(i_desc_rule_id) >= RULE_NUM) begin
            err_due = cycle;
            return;
        end
        if (i_desc_rule_valid) begin
            if (i_desc_upd_offset) begin
                for (int i = 0; i < TYPE_NUM; i++) begin
                    w.addr  = 32'(i);
                    w.wdata = 32'(i_desc_type_offset[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH]);
                    w.last  = 1'b0;
                    exp_q.push_back(w);
                end
            end
            for (int i = 0; i < TYPE_NUM; i++) begin
                w.addr  = 32'h0001_0100 + 32'(i);
                w.wdata = (32'(i_desc_type_data[i*TYPE_WIDTH +: TYPE_WIDTH]) << 16)
                        | 32'(i_desc_type_mask[i*TYPE_WIDTH +: TYPE_WIDTH]);
                w.last  = 1'b0;
                exp_q.push_back(w);
            end
            for (int k = 0; k < KEY_FILED_NUM; k++) begin
                w.addr  = 32'h0001_0200 + 32'(k);
                w.wdata = 32'(i_desc_key_offset[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH]);
                w.last  = 1'b0;
                exp_q.push_back(w);
            end
        end
        w.addr  = 32'h0001_0000 + 32'(i_desc_rule_id);
        w.wdata = i_desc_rule_valid ? 32'd1 : 32'd0;
        w.last  = 1'b1;
        exp_q.push_back(w);
    endtask

    // Monitor: checks presented writes against the queue head, status every cycle.
    always @(negedge i_clk) begin
        if (cycle >= 1) begin
            check("desc_ready", {31'b0, o_desc_ready}, {31'b0, (!i_rst && exp_q.size() == 0)});
            check("busy", {31'b0, o_busy}, {31'b0, (exp_q.size() != 0)});
            check("done", {31'b0, o_done}, {31'b0, (cycle == done_due)});
            check("err", {31'b0, o_err}, {31'b0, (cycle == err_due)});
            if (exp_q.size() == 0) begin
                check("wren_idle", {31'b0, o_rule_wren}, 32'd0);
            end else begin
                check("wren", {31'b0, o_rule_wren}, 32'd1);
                if (o_rule_wren) begin
                    check("addr", o_rule_addr, exp_q[0].addr);
                    check("wdata", o_rule_wdata, exp_q[0].wdata);
                    if (i_rule_wr_ready) begin
                        if (exp_q[0].last) done_due = cycle + 1;
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Sink ready generator.
    initial begin
        i_rule_wr_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                1: i_rule_wr_ready = ($urandom_range(0, 99) < 70);
                2: begin
                    if (pops - pat_base >= 10 && pat_idx < 4) begin
                        i_rule_wr_ready = pat[pat_idx];
                        pat_idx++;
                    end else begin
                        i_rule_wr_ready = 1'b1;
                    end
                end
                default: i_rule_wr_ready = 1'b1;
            endcase
        end
    end

    task automatic set_fixed(input logic [5:0] rid, input logic rv, input logic upd);
        i_desc_rule_id    = rid;
        i_desc_rule_valid = rv;
        i_desc_upd_offset = upd;
        for (int i = 0; i < TYPE_NUM; i++) begin
            i_desc_type_offset[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH] = TYPE_OFFSET_WIDTH'(4 * (i + 1));
            i_desc_type_data[i*TYPE_WIDTH +: TYPE_WIDTH] = TYPE_WIDTH'(16'h0800);
            i_desc_type_mask[i*TYPE_WIDTH +: TYPE_WIDTH] = TYPE_WIDTH'(16'hFFFF);
        end
        for (int k = 0; k < KEY_FILED_NUM; k++)
            i_desc_key_offset[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH] = KEY_OFFSET_WIDTH'(k);
    endtask

    task automatic set_random();
        i_desc_rule_id    = 6'($urandom_range(0, 11));
        i_desc_rule_valid = ($urandom_range(0, 3) != 0);
        i_desc_upd_offset = 1'($urandom);
        for (int i = 0; i < TYPE_NUM; i++) begin
            i_desc_type_offset[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH] = TYPE_OFFSET_WIDTH'($urandom);
            i_desc_type_data[i*TYPE_WIDTH +: TYPE_WIDTH] = TYPE_WIDTH'($urandom);
            i_desc_type_mask[i*TYPE_WIDTH +: TYPE_WIDTH] = TYPE_WIDTH'($urandom);
        end
        for (int k = 0; k < KEY_FILED_NUM; k++)
            i_desc_key_offset[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH] = KEY_OFFSET_WIDTH'($urandom);
    endtask

    // Called just after a posedge with fields already set; returns just after
    // the accepting edge.
    task automatic send_desc();
        int n = 0;
        i_desc_valid = 1'b1;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_desc_ready && n < 500);
        if (!o_desc_ready) check("accept_timeout", {31'b0, o_desc_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_desc_valid = 1'b0;
        model_push();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge i_clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        i_rst              = 1'b1;
        i_desc_valid       = 1'b0;
        i_desc_rule_id     = '0;
        i_desc_rule_valid  = 1'b0;
        i_desc_upd_offset  = 1'b0;
        i_desc_type_offset = '0;
        i_desc_type_data   = '0;
        i_desc_type_mask   = '0;
        i_desc_key_offset  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Full install, then install without offsets accepted in the o_done cycle.
        set_fixed(6'd3, 1'b1, 1'b1);
        send_desc();
        set_fixed(6'd3, 1'b1, 1'b0);
        send_desc();
        wait_drain();

        // Invalidate ignores upd_offset; out-of-range rule id is rejected.
        set_fixed(6'd5, 1'b0, 1'b1);
        send_desc();
        wait_drain();
        set_fixed(6'd9, 1'b1, 1'b1);
        send_desc();
        wait_drain();

        // Sink stall pattern 1,0,0,1 inside the key phase.
        pat_base = pops;
        pat_idx  = 0;
        rdy_mode = 2;
        set_fixed(6'd1, 1'b1, 1'b1);
        send_desc();
        wait_drain();
        rdy_mode = 0;
        repeat (2) @(posedge i_clk);
        #1;

        // Reset while the 6th write is presented, then a fresh install.
        base = pops;
        set_fixed(6'd2, 1'b1, 1'b1);
        send_desc();
        n = 0;
        while (pops - base < 5 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        done_due = -1;
        @(posedge i_clk);
        #1;
        set_fixed(6'd6, 1'b1, 1'b1);
        send_desc();
        wait_drain();

        // Randomized descriptors against a randomly stalling sink.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            set_random();
            send_desc();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge i_clk);
            #1;
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
